// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multi-cycle MIPS main controller, FETCH/DECODE/EXE/MEM/WB.
// Option   : MC_CTRL_RETIRE_CNT_EN adds the 32-bit retired-instruction count.
// Revision : 1.0
// ============================================================================
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        RegA,
  output logic [1:0]  RegDst,
  output logic [1:0]  Mem2Reg,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic [1:0]  ExtOp,
  output logic [1:0]  NPCOp,
  output logic        illegal,
  output logic [2:0]  state_o
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [7:0] c_TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tmo;

  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
  logic w_to_exe;

  assign w_rtype  = (op == 6'b000000);
  assign w_addu   = w_rtype && (funct == 6'b100001);
  assign w_subu   = w_rtype && (funct == 6'b100011);
  assign w_jr     = w_rtype && (funct == 6'b001000);
  assign w_ori    = (op == 6'b001101);
  assign w_lui    = (op == 6'b001111);
  assign w_lw     = (op == 6'b100011);
  assign w_sw     = (op == 6'b101011);
  assign w_beq    = (op == 6'b000100);
  assign w_j      = (op == 6'b000010);
  assign w_jal    = (op == 6'b000011);
  assign w_to_exe = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq;

  logic       w_pcwr, w_irwr, w_regwr, w_memwr, w_alusrc, w_ill;
  logic [1:0] w_regdst, w_m2r, w_extop, w_npcop;
  logic [2:0] w_aluop;

  always_comb begin
    w_next   = S_FETCH;
    w_pcwr   = 1'b0;
    w_irwr   = 1'b0;
    w_regwr  = 1'b0;
    w_memwr  = 1'b0;
    w_alusrc = 1'b0;
    w_ill    = 1'b0;
    w_regdst = 2'b00;
    w_m2r    = 2'b00;
    w_extop  = 2'b00;
    w_npcop  = 2'b00;
    w_aluop  = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_pcwr = 1'b1;
        w_irwr = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_j || w_jal) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b10;
          w_next  = w_jal ? S_WB : S_FETCH;
        end else if (w_jr) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b11;
        end else if (w_to_exe) begin
          w_next = S_EXE;
        end else begin
          w_ill = 1'b1;
        end
      end
      S_EXE: begin
        if (w_addu || w_subu) begin
          w_aluop = w_subu ? 3'b001 : 3'b000;
          w_next  = S_WB;
        end else if (w_ori || w_lui) begin
          w_aluop  = w_lui ? 3'b011 : 3'b010;
          w_alusrc = 1'b1;
          w_next   = S_WB;
        end else if (w_lw || w_sw) begin
          w_alusrc = 1'b1;
          w_extop  = 2'b01;
          w_next   = S_MEM;
        end else if (w_beq) begin
          w_aluop = 3'b001;
          w_extop = 2'b01;
          w_npcop = 2'b01;
          w_pcwr  = zero;
        end
      end
      S_MEM: begin
        w_memwr = w_sw;
        // A stall on the last permitted cycle aborts to FETCH with no writeback.
        if (mem_ready) begin
          w_next = w_lw ? S_WB : S_FETCH;
        end else if (r_tmo != c_TMO_LAST) begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        w_regwr = 1'b1;
        if (w_rtype) begin
          w_regdst = 2'b01;
        end else if (w_lw) begin
          w_m2r = 2'b01;
        end else if (w_jal) begin
          w_regdst = 2'b10;
          w_m2r    = 2'b10;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_tmo   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state != S_MEM) begin
        r_tmo <= 8'd0;
      end else if (!mem_ready) begin
        r_tmo <= r_tmo + 8'd1;
      end
    end
  end

  // Everything is held low while reset is asserted, whatever the state.
  assign PCWr     = reset & w_pcwr;
  assign IRWr     = reset & w_irwr;
  assign RegWrite = reset & w_regwr;
  assign MemWrite = reset & w_memwr;
  assign RegA     = 1'b0;
  assign RegDst   = reset ? w_regdst : 2'b00;
  assign Mem2Reg  = reset ? w_m2r    : 2'b00;
  assign ALUSrc   = reset & w_alusrc;
  assign ALUOp    = reset ? w_aluop  : 3'b000;
  assign ExtOp    = reset ? w_extop  : 2'b00;
  assign NPCOp    = reset ? w_npcop  : 2'b00;
  assign illegal  = reset & w_ill;
  assign state_o  = reset ? r_state  : 3'd0;

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic        w_retire;
  logic [31:0] r_retired;

  assign w_retire = (r_state == S_WB)
                 || (r_state == S_MEM    && w_sw && mem_ready)
                 || (r_state == S_EXE    && w_beq)
                 || (r_state == S_DECODE && (w_j || w_jr));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`else
  // No retirement counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Directed plus randomized instruction streams for mc_ctrl_fsm.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

  localparam int T = 8;
  localparam int I_ADDU = 0, I_SUBU = 1, I_ORI = 2, I_LUI = 3, I_LW = 4, I_SW = 5;
  localparam int I_BEQ = 6, I_J = 7, I_JAL = 8, I_JR = 9, I_ILL = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic PCWr, IRWr, RegWrite, MemWrite, RegA, ALUSrc, illegal;
  logic [1:0] RegDst, Mem2Reg, ExtOp, NPCOp;
  logic [2:0] ALUOp, state_o;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  mc_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .RegA(RegA), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ExtOp(ExtOp), .NPCOp(NPCOp),
    .illegal(illegal), .state_o(state_o)
`ifdef MC_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  logic [20:0] act;
  logic [20:0] exp_v = '0;
  logic [31:0] exp_ret = '0;
  bit chk_en = 1'b0;
  int lit_done = 0;
  int run_len = 0;
  int n_chk = 0, n_err = 0;

  assign act = {state_o, PCWr, IRWr, RegWrite, MemWrite, RegA, RegDst, Mem2Reg,
                ALUSrc, ALUOp, ExtOp, NPCOp, illegal};

  // Expected output vector for one step of an instruction, straight from the rules table.
  function automatic logic [20:0] ev(int ph, int t, logic z);
    logic pcwr = 0, irwr = 0, regwr = 0, memwr = 0, alusrc = 0, ill = 0;
    logic [1:0] regdst = 0, m2r = 0, extop = 0, npc = 0;
    logic [2:0] aluop = 0;
    case (ph)
      0: begin pcwr = 1; irwr = 1; end
      1: begin
        if (t == I_J || t == I_JAL) begin pcwr = 1; npc = 2'b10; end
        else if (t == I_JR) begin pcwr = 1; npc = 2'b11; end
        else if (t == I_ILL) ill = 1;
      end
      2: begin
        if (t == I_SUBU) aluop = 3'b001;
        if (t == I_ORI) begin aluop = 3'b010; alusrc = 1; end
        if (t == I_LUI) begin aluop = 3'b011; alusrc = 1; end
        if (t == I_LW || t == I_SW) begin alusrc = 1; extop = 2'b01; end
        if (t == I_BEQ) begin aluop = 3'b001; extop = 2'b01; npc = 2'b01; pcwr = z; end
      end
      3: memwr = (t == I_SW);
      4: begin
        regwr = 1;
        if (t == I_ADDU || t == I_SUBU) regdst = 2'b01;
        if (t == I_LW) m2r = 2'b01;
        if (t == I_JAL) begin regdst = 2'b10; m2r = 2'b10; end
      end
      default: ;
    endcase
    return {3'(ph), pcwr, irwr, regwr, memwr, 1'b0, regdst, m2r, alusrc, aluop, extop, npc, ill};
  endfunction

  task automatic enc(input int t, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (t)
      I_ADDU: begin o = 6'b000000; f = 6'b100001; end
      I_SUBU: begin o = 6'b000000; f = 6'b100011; end
      I_JR:   begin o = 6'b000000; f = 6'b001000; end
      I_ORI:  o = 6'b001101;
      I_LUI:  o = 6'b001111;
      I_LW:   o = 6'b100011;
      I_SW:   o = 6'b101011;
      I_BEQ:  o = 6'b000100;
      I_J:    o = 6'b000010;
      I_JAL:  o = 6'b000011;
      default: begin
        case ($urandom_range(0, 3))
          0: o = 6'b111111;
          1: begin o = 6'b000000; f = 6'b100000; end
          2: o = 6'b001000;
          default: begin o = 6'b000000; f = 6'b000000; end
        endcase
      end
    endcase
  endtask

  // Runs one instruction: k stall cycles before mem_ready, zf forces zero (-1 random),
  // rst_at aborts with reset at that step, lit is the literal cycle count (0 = none).
  task automatic run_instr(input int t, input int zf, input int k, input int rst_at, input int lit);
    int ph[$];
    int mem_n, mi;
    bit tmo;
    logic [5:0] o, f;
    enc(t, o, f);
    tmo = (k >= T);
    mem_n = tmo ? T : k + 1;
    ph.push_back(0);
    ph.push_back(1);
    case (t)
      I_ADDU, I_SUBU, I_ORI, I_LUI: begin ph.push_back(2); ph.push_back(4); end
      I_LW: begin
        ph.push_back(2);
        repeat (mem_n) ph.push_back(3);
        if (!tmo) ph.push_back(4);
      end
      I_SW: begin ph.push_back(2); repeat (mem_n) ph.push_back(3); end
      I_BEQ: ph.push_back(2);
      I_JAL: ph.push_back(4);
      default: ;
    endcase
    mi = 0;
    for (int i = 0; i < ph.size(); i++) begin
      op = o;
      funct = f;
      zero = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
      if (ph[i] == 3) begin
        mem_ready = (mi >= k);
        mi++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (i == rst_at) begin
        reset = 1'b0;
        exp_v = '0;
        @(posedge clk); #1;
        exp_ret = '0;
        reset = 1'b1;
        lit_done = 0;
        return;
      end
      exp_v = ev(ph[i], t, zero);
      @(posedge clk); #1;
    end
    if (t != I_ILL && !((t == I_LW || t == I_SW) && tmo)) exp_ret = exp_ret + 32'd1;
    lit_done = lit;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL outputs t=%0t got=%b required=%b", $time, act, exp_v);
      end
`ifdef MC_CTRL_RETIRE_CNT_EN
      n_chk++;
      if (retired !== exp_ret) begin
        n_err++;
        $display("FAIL retired t=%0t got=%0d required=%0d", $time, retired, exp_ret);
      end
`endif
      if (reset && state_o == 3'd0) begin
        if (lit_done != 0) begin
          n_chk++;
          if (run_len != lit_done) begin
            n_err++;
            $display("FAIL cycles t=%0t got=%0d required=%0d", $time, run_len, lit_done);
          end
        end
        run_len = 1;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, r, ra;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b1;
    run_instr(I_ADDU, -1, 0, -1, 4);
    run_instr(I_LW, -1, 3, -1, 8);
    run_instr(I_BEQ, 1, 0, -1, 3);
    run_instr(I_BEQ, 0, 0, -1, 3);
    run_instr(I_JAL, -1, 0, -1, 3);
    run_instr(I_SW, -1, 20, -1, 11);
    run_instr(I_ILL, -1, 0, -1, 2);
    run_instr(I_J, -1, 0, -1, 2);
    run_instr(I_JR, -1, 0, -1, 2);
    run_instr(I_ADDU, -1, 0, 3, 0);
    run_instr(I_ORI, -1, 0, -1, 4);
    run_instr(I_LW, -1, 0, -1, 5);
    run_instr(I_SW, -1, 0, -1, 4);
    run_instr(I_LUI, -1, 0, -1, 4);
    run_instr(I_SUBU, -1, 0, -1, 4);
    for (int n = 0; n < 400; n++) begin
      t = $urandom_range(0, 10);
      r = $urandom_range(0, 9);
      k = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 6) : $urandom_range(7, 12);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(t, -1, k, ra, 0);
    end
    run_instr(I_J, -1, 0, -1, 2);
    exp_v = ev(0, I_ADDU, zero);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
